// File: rtl/rhythm_judge_engine_pkg.sv
// rhythm_judge_engine_pkg
//   Shared judgment codes and default parameter values for the rhythm
//   judge engine and its per-lane judge.
package rhythm_judge_engine_pkg;

    typedef enum logic [1:0] {
        JUDGE_NONE    = 2'b00,
        JUDGE_PERFECT = 2'b01,
        JUDGE_GOOD    = 2'b10,
        JUDGE_MISS    = 2'b11
    } judge_e;

    localparam int DEF_LANES       = 4;
    localparam int DEF_TIME_W      = 10;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_PERFECT_WIN = 2;
    localparam int DEF_GOOD_WIN    = 5;
    localparam int DEF_PERFECT_PTS = 3;
    localparam int DEF_GOOD_PTS    = 1;
    localparam int DEF_SCORE_W     = 11;
    localparam int DEF_COMBO_W     = 10;

endpackage

// File: rtl/rhythm_judge_engine_lane_judge.sv
// rhythm_judge_engine_lane_judge
//   One lane of the judge: a DEPTH-entry circular queue of pending note
//   times and the head-versus-now judgment that decides whether the head
//   note is popped as PERFECT, GOOD or MISS this cycle.
// Ports
//   clock, reset_n, clear  clock, sync active-low reset, sync restart
//   now                    current game time
//   push_i, push_time_i    enqueue request for this lane
//   key_evt_i              press event (rising key edge) for this lane
//   pop_kind_o             judgment made this cycle (combinational)
//   full_o                 queue holds DEPTH notes
//   push_drop_o            push rejected because the queue was full
module rhythm_judge_engine_lane_judge
    import rhythm_judge_engine_pkg::*;
#(
    parameter int TIME_W      = DEF_TIME_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int PERFECT_WIN = DEF_PERFECT_WIN,
    parameter int GOOD_WIN    = DEF_GOOD_WIN
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [TIME_W-1:0] now,
    input  logic              push_i,
    input  logic [TIME_W-1:0] push_time_i,
    input  logic              key_evt_i,
    output judge_e            pop_kind_o,
    output logic              full_o,
    output logic              push_drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic signed [TIME_W:0] PERF_POS = (TIME_W+1)'(PERFECT_WIN);
    localparam logic signed [TIME_W:0] PERF_NEG = -PERF_POS;
    localparam logic signed [TIME_W:0] GOOD_POS = (TIME_W+1)'(GOOD_WIN);
    localparam logic signed [TIME_W:0] GOOD_NEG = -GOOD_POS;

    logic [TIME_W-1:0]      mem_q [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W:0]         count_q;
    logic signed [TIME_W:0] diff;
    logic                   pop;
    logic                   push_ok;

    // Zero-extend both operands so the difference is a true signed distance.
    always_comb begin
        diff       = $signed({1'b0, now}) - $signed({1'b0, mem_q[rd_ptr_q]});
        pop_kind_o = JUDGE_NONE;
        if (count_q != '0) begin
            if (diff > GOOD_POS) begin
                pop_kind_o = JUDGE_MISS;
            end else if (key_evt_i && diff >= PERF_NEG && diff <= PERF_POS) begin
                pop_kind_o = JUDGE_PERFECT;
            end else if (key_evt_i && diff >= GOOD_NEG) begin
                pop_kind_o = JUDGE_GOOD;
            end
        end
    end

    assign pop         = (pop_kind_o != JUDGE_NONE);
    assign full_o      = (count_q == DEPTH_C);
    // A pop in the same cycle frees the slot, so a full lane still accepts.
    assign push_ok     = push_i && (!full_o || pop);
    assign push_drop_o = push_i && full_o && !pop;

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_time_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rhythm_judge_engine.sv
// rhythm_judge_engine
//   Multi-lane rhythm judge: routes timestamped notes into per-lane queues,
//   turns key levels into press events, and accumulates score, combo and
//   max combo from the per-lane judgments. All outputs except lane_full
//   are registered; lane_full reflects the lane queue state directly.
// Ports
//   clock, reset_n, clear          clock, sync active-low reset, sync restart
//   now                            current game time
//   note_valid/note_lane/note_time note push
//   keys                           synchronised key levels
//   judge_valid, judge_kind        per-lane judgment pulse and 2-bit code
//   score, combo, max_combo        saturating game counters
//   lane_full, overflow            queue full flags, sticky drop flag
module rhythm_judge_engine
    import rhythm_judge_engine_pkg::*;
#(
    parameter int LANES       = DEF_LANES,
    parameter int TIME_W      = DEF_TIME_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int PERFECT_WIN = DEF_PERFECT_WIN,
    parameter int GOOD_WIN    = DEF_GOOD_WIN,
    parameter int PERFECT_PTS = DEF_PERFECT_PTS,
    parameter int GOOD_PTS    = DEF_GOOD_PTS,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int COMBO_W     = DEF_COMBO_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic [TIME_W-1:0]        now,
    input  logic                     note_valid,
    input  logic [$clog2(LANES)-1:0] note_lane,
    input  logic [TIME_W-1:0]        note_time,
    input  logic [LANES-1:0]         keys,
    output logic [LANES-1:0]         judge_valid,
    output logic [2*LANES-1:0]       judge_kind,
    output logic [SCORE_W-1:0]       score,
    output logic [COMBO_W-1:0]       combo,
    output logic [COMBO_W-1:0]       max_combo,
    output logic [LANES-1:0]         lane_full,
    output logic                     overflow
);

    localparam int LANE_W = $clog2(LANES);
    localparam int CNT_W  = $clog2(LANES + 1);

    logic [LANES-1:0]   keys_q;
    logic [LANES-1:0]   key_evt;
    logic [LANES-1:0]   lane_push;
    logic [LANES-1:0]   lane_drop;
    judge_e             lane_kind [LANES];

    logic [LANES-1:0]   judge_valid_q, judge_valid_d;
    logic [2*LANES-1:0] judge_kind_q, judge_kind_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [COMBO_W-1:0] max_combo_q, max_combo_d;
    logic               overflow_q, overflow_d;

    logic [CNT_W-1:0]   n_perf;
    logic [CNT_W-1:0]   n_good;
    logic [CNT_W:0]     n_hits;
    logic               any_miss;
    logic [SCORE_W:0]   score_sum;
    logic [COMBO_W:0]   combo_sum;

    assign key_evt = keys & ~keys_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_push[g] = note_valid && (note_lane == LANE_W'(g));

        rhythm_judge_engine_lane_judge #(
            .TIME_W      (TIME_W),
            .DEPTH       (DEPTH),
            .PERFECT_WIN (PERFECT_WIN),
            .GOOD_WIN    (GOOD_WIN)
        ) u_lane_judge (
            .clock       (clock),
            .reset_n     (reset_n),
            .clear       (clear),
            .now         (now),
            .push_i      (lane_push[g]),
            .push_time_i (note_time),
            .key_evt_i   (key_evt[g]),
            .pop_kind_o  (lane_kind[g]),
            .full_o      (lane_full[g]),
            .push_drop_o (lane_drop[g])
        );
    end

    always_comb begin
        n_perf        = '0;
        n_good        = '0;
        any_miss      = 1'b0;
        judge_valid_d = '0;
        judge_kind_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            judge_kind_d[2*i +: 2] = lane_kind[i];
            judge_valid_d[i]       = (lane_kind[i] != JUDGE_NONE);
            if (lane_kind[i] == JUDGE_PERFECT) n_perf = n_perf + CNT_W'(1);
            if (lane_kind[i] == JUDGE_GOOD)    n_good = n_good + CNT_W'(1);
            if (lane_kind[i] == JUDGE_MISS)    any_miss = 1'b1;
        end
        n_hits = {1'b0, n_perf} + {1'b0, n_good};

        // One spare bit on the sums catches the carry used for clamping.
        score_sum = {1'b0, score_q}
                  + (SCORE_W+1)'(PERFECT_PTS) * (SCORE_W+1)'(n_perf)
                  + (SCORE_W+1)'(GOOD_PTS) * (SCORE_W+1)'(n_good);
        score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

        combo_sum = {1'b0, combo_q} + (COMBO_W+1)'(n_hits);
        if (any_miss) begin
            combo_d = '0;
        end else begin
            combo_d = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
        end
        max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
        overflow_d  = overflow_q | (|lane_drop);
    end

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            keys_q        <= '0;
            judge_valid_q <= '0;
            judge_kind_q  <= '0;
            score_q       <= '0;
            combo_q       <= '0;
            max_combo_q   <= '0;
            overflow_q    <= 1'b0;
        end else begin
            keys_q        <= keys;
            judge_valid_q <= judge_valid_d;
            judge_kind_q  <= judge_kind_d;
            score_q       <= score_d;
            combo_q       <= combo_d;
            max_combo_q   <= max_combo_d;
            overflow_q    <= overflow_d;
        end
    end

    assign judge_valid = judge_valid_q;
    assign judge_kind  = judge_kind_q;
    assign score       = score_q;
    assign combo       = combo_q;
    assign max_combo   = max_combo_q;
    assign overflow    = overflow_q;

endmodule
